// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin slave-bus arbiter.
package g20_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_MSTR = 4;
  localparam int DEF_TIMEOUT  = 16;
  localparam int ADDR_W       = 48;
  localparam int DATA_W       = 16;
  localparam int CNT_W        = 8;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Master-side request/grant bundle plus the shared slave bus.
interface bus_arbiter_rr_if
  import g20_arb_pkg::*;
#(
  parameter int NUM_MSTR = DEF_NUM_MSTR
) ();

  // Handshake: a master holds request high until it sees its Xend_mstr pulse;
  // itsyours marks the owner, the slave ends a transfer with a one-cycle Xend.
  logic [NUM_MSTR-1:0]             request;
  logic [NUM_MSTR-1:0]             itsyours;
  logic [NUM_MSTR-1:0]             Xend_mstr;
  logic [NUM_MSTR-1:0][ADDR_W-1:0] QmAddr;
  logic [NUM_MSTR-1:0][DATA_W-1:0] mdout;
  logic [NUM_MSTR-1:0][DATA_W-1:0] Mdin;
  logic [ADDR_W-1:0]               Adr;
  logic [DATA_W-1:0]               dataIn;
  logic [DATA_W-1:0]               dbus_out;
  logic                            select_slave;
  logic                            Xend;
  logic                            timeout_err;

  // Arbiter side: it masters the shared slave bus.
  modport master (
    input  request, QmAddr, mdout, dbus_out, Xend,
    output itsyours, Xend_mstr, Mdin, Adr, dataIn, select_slave, timeout_err
  );

  // Environment side: bus masters plus the slave.
  modport slave (
    output request, QmAddr, mdout, dbus_out, Xend,
    input  itsyours, Xend_mstr, Mdin, Adr, dataIn, select_slave, timeout_err
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner search: first set request at or above i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_MSTR = 4,
  parameter int PW       = 2
) (
  input  logic [NUM_MSTR-1:0] i_req,
  input  logic [PW-1:0]       i_ptr,
  output logic [PW-1:0]       o_winner,
  output logic                o_valid
);

  logic [PW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int i = NUM_MSTR - 1; i >= 0; i--) begin
      w_idx = PW'((int'(i_ptr) + i) % NUM_MSTR);
      if (i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter granting one of NUM_MSTR masters the single slave bus,
// with transfer timeout and abort-on-request-drop.
module bus_arbiter_rr
  import g20_arb_pkg::*;
#(
  parameter int NUM_MSTR = DEF_NUM_MSTR,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                        Qclock,
  input  logic                        BusReset,
  bus_arbiter_rr_if.master            bus,
  output arb_state_e                  o_dbg_state,
  output logic [$clog2(NUM_MSTR)-1:0] o_dbg_rr_ptr
);

  localparam int              PW      = $clog2(NUM_MSTR);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e          r_state, w_state_nxt;
  logic [PW-1:0]       r_rr_ptr, w_ptr_nxt;
  logic [PW-1:0]       r_winner, w_winner_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_MSTR-1:0] r_itsyours, w_grant_nxt;
  logic [NUM_MSTR-1:0] r_xend_mstr, w_xend_nxt;
  logic                r_select, w_sel_nxt;
  logic                r_timeout_err, w_to_nxt;

  logic [PW-1:0]       w_pick;
  logic                w_pick_valid;
  logic [NUM_MSTR-1:0] w_pick_oh;
  logic [NUM_MSTR-1:0] w_win_oh;
  logic [PW-1:0]       w_ptr_adv;

  rr_pick #(.NUM_MSTR(NUM_MSTR), .PW(PW)) u_pick (
    .i_req    (bus.request),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  assign w_pick_oh = NUM_MSTR'(1) << w_pick;
  assign w_win_oh  = NUM_MSTR'(1) << r_winner;
  assign w_ptr_adv = PW'((int'(r_winner) + 1) % NUM_MSTR);

  always_ff @(posedge Qclock or negedge BusReset) begin
    if (!BusReset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_winner      <= '0;
      r_cnt         <= '0;
      r_itsyours    <= '0;
      r_xend_mstr   <= '0;
      r_select      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_ptr_nxt;
      r_winner      <= w_winner_nxt;
      r_cnt         <= w_cnt_nxt;
      r_itsyours    <= w_grant_nxt;
      r_xend_mstr   <= w_xend_nxt;
      r_select      <= w_sel_nxt;
      r_timeout_err <= w_to_nxt;
    end
  end

  // Every exit from BUSY clears grant/select and advances the pointer; slave
  // Xend beats a request drop, which beats the timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_rr_ptr;
    w_winner_nxt = r_winner;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = r_itsyours;
    w_sel_nxt    = r_select;
    w_xend_nxt   = '0;
    w_to_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_pick_valid) begin
          w_state_nxt  = ST_BUSY;
          w_winner_nxt = w_pick;
          w_grant_nxt  = w_pick_oh;
          w_sel_nxt    = 1'b1;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (bus.Xend || !bus.request[r_winner] || (r_cnt == TO_LAST)) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
          w_sel_nxt   = 1'b0;
          w_ptr_nxt   = w_ptr_adv;
          w_cnt_nxt   = '0;
          if (bus.Xend) begin
            w_xend_nxt = w_win_oh;
          end else if (bus.request[r_winner]) begin
            w_xend_nxt = w_win_oh;
            w_to_nxt   = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_sel_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.Adr    = '0;
    bus.dataIn = '0;
    bus.Mdin   = '0;
    if (r_state == ST_BUSY) begin
      bus.Adr            = bus.QmAddr[r_winner];
      bus.dataIn         = bus.mdout[r_winner];
      bus.Mdin[r_winner] = bus.dbus_out;
    end
  end

  assign bus.itsyours     = r_itsyours;
  assign bus.Xend_mstr    = r_xend_mstr;
  assign bus.select_slave = r_select;
  assign bus.timeout_err  = r_timeout_err;
  assign o_dbg_state      = r_state;
  assign o_dbg_rr_ptr     = r_rr_ptr;

endmodule
